// File: rtl/alu_j_pkg.sv
// alu_j_pkg - shared constants for the Jac1-8 ALU.
//   Width constants, opcode encodings and status bit indices used by
//   alu_j and alu_j_shifter. OP_ROL/OP_ROR are only decoded when the
//   design is built with ALU_J_ROTATE_EN defined.
package alu_j_pkg;
    localparam int DATA_WIDTH      = 8;
    localparam int NUM_OPCODE_BITS = 5;
    localparam int PARAM_BITS      = 8;
    localparam int NUM_STATUS_BITS = 3;

    localparam logic [NUM_OPCODE_BITS-1:0] OP_NOP = 5'b00000;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_ADD = 5'b00001;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_SUB = 5'b00010;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_AND = 5'b00011;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_OR  = 5'b00100;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_NOT = 5'b00101;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_XOR = 5'b00110;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_SHL = 5'b00111;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_SHR = 5'b01000;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_VAL = 5'b01001;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_ROL = 5'b01010;
    localparam logic [NUM_OPCODE_BITS-1:0] OP_ROR = 5'b01011;

    localparam int ST_CARRY  = 0;
    localparam int ST_BORROW = 1;
    localparam int ST_ZERO   = 2;
endpackage

// File: rtl/alu_j_shifter.sv
// alu_j_shifter - logical shifter (and optional rotator) for alu_j.
//   operand_i : value to shift
//   amount_i  : shift amount (full width; >= DATA_WIDTH clears the value)
//   dir_i     : 0 = left, 1 = right
//   rotate_i  : 1 = rotate by amount_i[2:0] (only with ALU_J_ROTATE_EN)
//   value_o   : shifted / rotated value
//   carry_o   : shift: any 1 bit shifted out; rotate: last bit carried
//               around the word (0 for a zero rotate amount)
// Build option: ALU_J_ROTATE_EN enables the rotate path.
module alu_j_shifter
    import alu_j_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic [PARAM_BITS-1:0] amount_i,
    input  logic                  dir_i,
    input  logic                  rotate_i,
    output logic [DATA_WIDTH-1:0] value_o,
    output logic                  carry_o
);
    // Double-width window: the half the operand moves out of collects
    // the bits that fall off the edge, so carry is just an OR of it.
    logic [2*DATA_WIDTH-1:0] win;
    logic [2:0]              amt3;

    assign amt3 = amount_i[2:0];

    always_comb begin
        win     = '0;
        value_o = '0;
        carry_o = 1'b0;
        if (amount_i >= PARAM_BITS'(DATA_WIDTH)) begin
            value_o = '0;
            carry_o = |operand_i;
        end else if (!dir_i) begin
            win     = {{DATA_WIDTH{1'b0}}, operand_i} << amt3;
            value_o = win[DATA_WIDTH-1:0];
            carry_o = |win[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
            win     = {operand_i, {DATA_WIDTH{1'b0}}} >> amt3;
            value_o = win[2*DATA_WIDTH-1:DATA_WIDTH];
            carry_o = |win[DATA_WIDTH-1:0];
        end
`ifdef ALU_J_ROTATE_EN
        // Rotate only looks at amount[2:0]. The last bit out of bit 7
        // (left) lands in bit 0; the last out of bit 0 (right) lands in bit 7.
        if (rotate_i) begin
            if (!dir_i) begin
                win     = {operand_i, operand_i} << amt3;
                value_o = win[2*DATA_WIDTH-1:DATA_WIDTH];
                carry_o = (amt3 != 3'd0) && value_o[0];
            end else begin
                win     = {operand_i, operand_i} >> amt3;
                value_o = win[DATA_WIDTH-1:0];
                carry_o = (amt3 != 3'd0) && value_o[DATA_WIDTH-1];
            end
        end
`endif
    end

`ifndef ALU_J_ROTATE_EN
    logic unused_rotate;
    assign unused_rotate = rotate_i;
`endif
endmodule

// File: rtl/alu_j.sv
// alu_j - 8-bit ALU of the Jac1-8 datapath with a registered flag copy.
//   clk      : clock
//   reset    : synchronous active-high, clears flags
//   opcode   : operation select
//   operand1 : first operand
//   operand2 : second operand
//   param    : shift amount / literal
//   result   : combinational result
//   status   : combinational {zero, borrow, carry}
//   flags    : status of the last valid non-NOP operation
// Build option: ALU_J_ROTATE_EN adds ROL/ROR.
module alu_j
    import alu_j_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_OPCODE_BITS-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]      operand1,
    input  logic [DATA_WIDTH-1:0]      operand2,
    input  logic [PARAM_BITS-1:0]      param,
    output logic [DATA_WIDTH-1:0]      result,
    output logic [NUM_STATUS_BITS-1:0] status,
    output logic [NUM_STATUS_BITS-1:0] flags
);
    logic [NUM_STATUS_BITS-1:0] flags_q, flags_d;
    logic [DATA_WIDTH-1:0]      sh_val;
    logic                       sh_carry;
    logic                       sh_dir;
    logic                       sh_rot;
    logic                       valid_op;
    logic [DATA_WIDTH:0]        sum;

`ifdef ALU_J_ROTATE_EN
    assign sh_dir = (opcode == OP_SHR) || (opcode == OP_ROR);
    assign sh_rot = (opcode == OP_ROL) || (opcode == OP_ROR);
`else
    assign sh_dir = (opcode == OP_SHR);
    assign sh_rot = 1'b0;
`endif

    alu_j_shifter u_shifter (
        .operand_i (operand1),
        .amount_i  (param),
        .dir_i     (sh_dir),
        .rotate_i  (sh_rot),
        .value_o   (sh_val),
        .carry_o   (sh_carry)
    );

    assign sum = {1'b0, operand1} + {1'b0, operand2};

    always_comb begin
        result   = '0;
        status   = '0;
        valid_op = 1'b1;
        unique case (opcode)
            OP_ADD: begin
                result           = sum[DATA_WIDTH-1:0];
                status[ST_CARRY] = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                result            = operand1 - operand2;
                status[ST_BORROW] = (operand1 < operand2);
            end
            OP_AND: result = operand1 & operand2;
            OP_OR:  result = operand1 | operand2;
            OP_XOR: result = operand1 ^ operand2;
            OP_NOT: result = ~operand2;
            OP_SHL, OP_SHR: begin
                result           = sh_val;
                status[ST_CARRY] = sh_carry;
            end
            OP_VAL: result = param;
`ifdef ALU_J_ROTATE_EN
            OP_ROL, OP_ROR: begin
                result           = sh_val;
                status[ST_CARRY] = sh_carry;
            end
`endif
            default: valid_op = 1'b0;
        endcase
        // Zero means the full-precision result is zero, so a carry-out
        // (e.g. 255+1) suppresses it. NOP/reserved never set it.
        status[ST_ZERO] = valid_op && (result == '0) && !status[ST_CARRY];
    end

    always_comb begin
        flags_d = flags_q;
        if (valid_op) flags_d = status;
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    assign flags = flags_q;
endmodule

// File: tb/tb_alu_j.sv
module tb_alu_j;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] opcode;
    logic [7:0] operand1, operand2, param;
    logic [7:0] result;
    logic [2:0] status, flags;

    alu_j dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .operand1 (operand1),
        .operand2 (operand2),
        .param    (param),
        .result   (result),
        .status   (status),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  res;
        int  st;
        int  fl;
        bit  chk_fl;
        int  op;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_flags = 0;
    bit   flags_known = 0;

    // Reference model: plain integer arithmetic from the opcode table.
    function automatic void ref_alu(input int op, input int a, input int b, input int p,
                                    output int res, output int st, output bit valid);
        int c, bw, n;
        c = 0; bw = 0; res = 0; valid = 1;
        case (op)
            1: begin res = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            2: begin res = (a - b + 256) % 256; bw = (a < b) ? 1 : 0; end
            3: res = a & b;
            4: res = a | b;
            5: res = 255 - b;
            6: res = a ^ b;
            7: if (p >= 8) begin res = 0; c = (a != 0) ? 1 : 0; end
               else begin res = (a * (1 << p)) % 256; c = ((a * (1 << p)) > 255) ? 1 : 0; end
            8: if (p >= 8) begin res = 0; c = (a != 0) ? 1 : 0; end
               else begin res = a / (1 << p); c = ((a % (1 << p)) != 0) ? 1 : 0; end
            9: res = p;
`ifdef ALU_J_ROTATE_EN
            10: begin
                n = p % 8;
                res = ((a * (1 << n)) + (a / (1 << (8 - n)))) % 256;
                c = (n != 0) ? ((a / (1 << (8 - n))) % 2) : 0;
            end
            11: begin
                n = p % 8;
                res = ((a / (1 << n)) + (a * (1 << (8 - n)))) % 256;
                c = (n != 0) ? ((a / (1 << (n - 1))) % 2) : 0;
            end
`endif
            default: valid = 0;
        endcase
        st = valid ? (c + 2 * bw + ((res == 0 && c == 0) ? 4 : 0)) : 0;
    endfunction

    // Drive one operation just after a rising edge and queue what the
    // monitor should see before the next one.
    task automatic drive(input bit rst, input int op, input int a, input int b, input int p);
        exp_t e;
        int   res, st;
        bit   valid;
        @(posedge clk);
        #1;
        reset = rst; opcode = 5'(op); operand1 = 8'(a); operand2 = 8'(b); param = 8'(p);
        ref_alu(op, a, b, p, res, st, valid);
        e.res = res; e.st = st; e.fl = model_flags; e.chk_fl = flags_known; e.op = op;
        exp_q.push_back(e);
        if (rst) begin model_flags = 0; flags_known = 1; end
        else if (valid) model_flags = st;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (int'(result) != e.res) begin
                n_fail++;
                $display("FAIL result op=%0d: got %0h want %0h", e.op, result, e.res);
            end
            n_checks++;
            if (int'(status) != e.st) begin
                n_fail++;
                $display("FAIL status op=%0d: got %b want %0b", e.op, status, e.st);
            end
            if (e.chk_fl) begin
                n_checks++;
                if (int'(flags) != e.fl) begin
                    n_fail++;
                    $display("FAIL flags op=%0d: got %b want %0b", e.op, flags, e.fl);
                end
            end
        end
    end

    initial begin
        int op, p;
        reset = 1'b1; opcode = '0; operand1 = '0; operand2 = '0; param = '0;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 1, 3, 0);
        drive(0, 1, 255, 2, 0);
        drive(0, 1, 255, 1, 0);
        drive(0, 0, 7, 7, 0);
        drive(0, 31, 9, 9, 9);
        drive(0, 10, 8'h81, 0, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 2, 2, 5, 0);
        drive(0, 2, 5, 5, 0);
        drive(1, 2, 2, 5, 0);
        drive(0, 3, 8'hCC, 8'h33, 0);
        drive(0, 4, 8'hF0, 8'h0F, 0);
        drive(0, 6, 8'hF0, 8'hF0, 0);
        drive(0, 5, 8'h11, 8'hAC, 0);
        drive(0, 7, 8'h81, 0, 1);
        drive(0, 8, 8'h01, 0, 1);
        drive(0, 9, 0, 0, 8'h5A);
        drive(0, 9, 0, 0, 0);
        drive(0, 7, 8'h01, 0, 8);
        drive(0, 8, 8'h00, 0, 200);
        drive(0, 8, 8'h80, 0, 7);
        drive(0, 11, 8'h01, 0, 1);
        drive(0, 10, 8'h00, 0, 3);
        for (int i = 0; i < 400; i++) begin
            op = (i % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 11));
            p  = (i % 3 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
            drive(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0, op,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), p);
        end
        // Let the monitor drain the queue, bounded in cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_j.md
# alu_j

Combinational 8-bit arithmetic/logic unit of the Jac1-8 datapath, with a clocked flag register. Given an opcode, two operands and an immediate parameter, it produces a result and a 3-bit status vector in the same cycle. It also keeps a registered copy of the last meaningful status for the control unit's conditional branches.

## Interface
- DataWidth, 8, operand/result width
- NumOpCodeBits, 5, opcode width
- ParamBits, 8, immediate parameter width
- NumStatusBits, 3, status width
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high; clears `flags` on the rising clk edge
- opcode  in  5  operation select
- operand1  in  8  first operand
- operand2  in  8  second operand
- param  in  8  immediate: shift amount or literal value
- result  out  8  combinational result
- status  out  3  combinational flags: [0] carry/overflow, [1] borrow, [2] zero
- flags  out  3  registered status

## Operation
Opcodes:
- NOP 00000: result 0, status 000.
- ADD 00001: {c,r} = operand1 + operand2 (9-bit); result r; status[0] = c.
- SUB 00010: result = operand1 − operand2 mod 256; status[1] = (operand1 < operand2).
- AND 00011 / OR 00100 / XOR 00110: bitwise operand1 op operand2.
- NOT 00101: result = ~operand2; operand1 ignored.
- SHL 00111: result = operand1 << param. status[0] = 1 if any 1 bit is shifted out. param ≥ 8 gives result 0, with carry = (operand1 != 0).
- SHR 01000: logical right shift, same carry rule for bits shifted out the bottom.
- VAL 01001: result = param[7:0].
- Reserved opcodes (01010–11111, minus the rotate opcodes when enabled): behave as NOP.

Status rules:
- Zero flag status[2] = 1 iff the full-precision result is zero: result == 0 and status[0] == 0. Example: 255+1 gives result 0 with status 001.
- Zero flag is never set for NOP or reserved opcodes.
- Any flag not named for an opcode is 0.

## Timing
- `result` and `status` are purely combinational from the inputs; zero latency. They settle within the same cycle with no clk dependency.
- On each clk rising edge:
  - reset = 1: flags ← 000 (takes priority over everything).
  - Otherwise, if opcode is a valid non-NOP opcode: flags ← status.
  - Otherwise (NOP or reserved): flags hold their value.
- The new `flags` value is visible one cycle after the operation is presented. Reset mid-operation clears `flags` only; the combinational outputs are unaffected.

## Configuration
- ALU_J_ROTATE_EN defined: two extra opcodes are valid.
  - ROL 01010: rotate operand1 left by param[2:0]; status[0] = last bit rotated out of bit 7 (0 when the amount is 0).
  - ROR 01011: the mirror of ROL.
  - Zero flag for ROL/ROR = (result == 0).
  - Both opcodes update `flags`.
- ALU_J_ROTATE_EN undefined: 01010 and 01011 are reserved and behave as NOP.

## Structure
- Shared package alu_j_pkg: opcode localparams (OP_NOP…OP_VAL, OP_ROL, OP_ROR), width constants, and status bit indices (ST_CARRY = 0, ST_BORROW = 1, ST_ZERO = 2).
- One sub-module, alu_j_shifter, handles SHL/SHR and, when compiled in, ROL/ROR.
  - Inputs: operand, amount, direction, rotate.
  - Outputs: shifted value and carry.
- The top level holds the opcode decode, the arithmetic/logic operations, zero-flag generation and the flags register.

## Test plan
- ADD 1+3 → result 4, status 000. ADD 255+2 → result 1, status 001. ADD 255+1 → result 0, status 001. ADD 0+0 → result 0, status 100.
- SUB 2−5 → result 0xFD, status 010. SUB 5−5 → result 0, status 100.
- AND 0xCC,0x33 → 0x00, status 100. OR 0xF0,0x0F → 0xFF, status 000. XOR 0xF0,0xF0 → 0x00, status 100. NOT (op2 = 0xAC) → 0x53, status 000.
- SHL 0x81 by param 1 → 0x02, status 001. SHR 0x01 by param 1 → 0x00, status 001. VAL with param 0x5A → 0x5A, status 000.
- Flags register:
  - Reset high for one edge → flags 000.
  - ADD 255+1 then a clk edge → flags 001.
  - NOP or reserved opcode 11111 then a clk edge → flags remain 001, result 0.
- With ALU_J_ROTATE_EN: ROL 0x81 by 1 → 0x03, status 001. Without it: opcode 01010 → result 0, status 000, flags held.
